// File: rtl/mat_mult_pkg.sv
// Shared types and saturation helper for the sequential NxN matrix multiplier.
package mat_mult_pkg;

   typedef enum logic [1:0] {
      MODE_MAT     = 2'b00,
      MODE_ELEM    = 2'b01,
      MODE_MAC     = 2'b10,
      MODE_ILLEGAL = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      DRAIN
   } state_e;

   // Headroom above W + clog2(N) so the running sum keeps its sign bit.
   localparam int ACC_GUARD = 1;
   localparam int SAT_XW    = 128;

   function automatic logic signed [SAT_XW-1:0] sat_w(input logic signed [SAT_XW-1:0] value,
                                                      input int width);
      logic signed [SAT_XW-1:0] hi;
      logic signed [SAT_XW-1:0] lo;
      hi = 128'sd1 <<< (width - 1);
      hi = hi - 128'sd1;
      lo = -hi - 128'sd1;
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/mat_mult_seq_mac_cell.sv
// One grid cell: registered product, scale by FRAC, saturating accumulate,
// final saturation to W and a per-operation overflow flag.
module mac_cell
   import mat_mult_pkg::*;
#(
   parameter int W     = 27,
   parameter int FRAC  = 0,
   parameter int ACC_W = 30
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                init_en,
   input  logic                mul_en,
   input  logic                acc_en,
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   input  logic signed [W-1:0] init_i,
   output logic signed [W-1:0] res_o,
   output logic                ovf_o
);
   localparam int PW = 2 * W;

   logic signed [PW-1:0]     p_q, p_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     ovf_q, ovf_d;
   logic signed [ACC_W-1:0]  term, acc_nxt;
   logic signed [SAT_XW-1:0] scaled_x, term_x, raw_sum, sum_x, res_x;
   logic                     term_sat, sum_sat, res_sat;

   always_comb begin
      p_d = p_q;
      if (mul_en) p_d = PW'(a_i) * PW'(b_i);

      scaled_x = SAT_XW'(p_q >>> FRAC);
      term_x   = sat_w(scaled_x, ACC_W);
      term_sat = (term_x != scaled_x);
      term     = term_x[ACC_W-1:0];

      raw_sum  = SAT_XW'(acc_q) + SAT_XW'(term);
      sum_x    = sat_w(raw_sum, ACC_W);
      sum_sat  = (sum_x != raw_sum);
      acc_nxt  = sum_x[ACC_W-1:0];

      // The output always reflects the pending product so completion needs no extra cycle.
      res_x    = sat_w(SAT_XW'(acc_nxt), W);
      res_sat  = (res_x != SAT_XW'(acc_nxt));
      res_o    = res_x[W-1:0];
      ovf_o    = ovf_q | term_sat | sum_sat | res_sat;

      acc_d = acc_q;
      ovf_d = ovf_q;
      if (init_en) begin
         acc_d = ACC_W'(init_i);
         ovf_d = 1'b0;
      end else if (acc_en) begin
         acc_d = acc_nxt;
         ovf_d = ovf_q | term_sat | sum_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_q   <= '0;
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         p_q   <= p_d;
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential NxN fixed-point matrix multiplier using an outer-product schedule.
// state | meaning
// IDLE  | waiting for start; result held
// MULT  | one column/row pair per cycle into the product grid
// DRAIN | last product folded in, result written, done pulsed next cycle
module mat_mult_seq
   import mat_mult_pkg::*;
#(
   parameter int N    = 6,
   parameter int W    = 27,
   parameter int FRAC = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [N*N*W-1:0] dataa,
   input  logic [N*N*W-1:0] datab,
   output logic             busy,
   output logic             done,
   output logic [N*N*W-1:0] result,
   output logic             overflow
);
   localparam int ACC_W = W + $clog2(N) + ACC_GUARD;
   localparam int K_W   = $clog2(N);
   localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

   typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

   state_e         state_q, state_d;
   mode_e          mode_q, mode_d;
   logic [K_W-1:0] k_q, k_d;
   mat_t           a_q, a_d, b_q, b_d, result_q, result_d;
   logic           busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic           init_en, mul_en, acc_en;
   mode_e          mode_in;
   mat_t           res_all;
   logic [N*N-1:0] ovf_all;

   assign mode_in = mode_e'(mode);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      k_d      = k_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      init_en  = 1'b0;
      mul_en   = 1'b0;
      acc_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !busy_q && mode_in != MODE_ILLEGAL) begin
               a_d     = mat_t'(dataa);
               b_d     = mat_t'(datab);
               mode_d  = mode_in;
               k_d     = '0;
               busy_d  = 1'b1;
               ovf_d   = 1'b0;
               init_en = 1'b1;
               state_d = MULT;
            end
         end
         MULT: begin
            mul_en = 1'b1;
            acc_en = (k_q != '0);
            if (mode_q == MODE_ELEM || k_q == K_LAST) state_d = DRAIN;
            else                                      k_d     = k_q + 1'b1;
         end
         DRAIN: begin
            result_d = res_all;
            ovf_d    = |ovf_all;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            k_d      = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mode_q   <= MODE_MAT;
         k_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         k_q      <= k_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [W-1:0] a_sel, b_sel, init_sel;

         // Column k of A and row k of B are broadcast across the grid.
         always_comb begin
            a_sel = a_q[i][k_q];
            b_sel = b_q[k_q][j];
            if (mode_q == MODE_ELEM) begin
               a_sel = a_q[i][j];
               b_sel = b_q[i][j];
            end
            init_sel = (mode_in == MODE_MAC) ? result_q[i][j] : '0;
         end

         mac_cell #(.W(W), .FRAC(FRAC), .ACC_W(ACC_W)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .init_en (init_en),
            .mul_en  (mul_en),
            .acc_en  (acc_en),
            .a_i     (a_sel),
            .b_i     (b_sel),
            .init_i  (init_sel),
            .res_o   (res_all[i][j]),
            .ovf_o   (ovf_all[i*N+j])
         );
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Randomised and directed bench for mat_mult_seq, two instances (FRAC=0 and FRAC=16).
module tb_mat_mult_seq;
   localparam int N    = 3;
   localparam int W    = 27;
   localparam int ACCW = W + $clog2(N) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [N*N*W-1:0] dataa = '0;
   logic [N*N*W-1:0] datab = '0;
   logic             busy0, done0, ovf0, busy1, done1, ovf1;
   logic [N*N*W-1:0] res0, res1;

   int     checks = 0;
   int     failures = 0;
   longint ma[N][N];
   longint mb[N][N];
   longint prev[2][N][N];
   longint expr[2][N][N];
   bit     eovf[2];

   always #5 clk = ~clk;

   mat_mult_seq #(.N(N), .W(W), .FRAC(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dataa(dataa), .datab(datab),
      .busy(busy0), .done(done0), .result(res0), .overflow(ovf0));

   mat_mult_seq #(.N(N), .W(W), .FRAC(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dataa(dataa), .datab(datab),
      .busy(busy1), .done(done1), .result(res1), .overflow(ovf1));

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint clampv(input longint v, input int bits);
      longint hi, lo;
      hi = (64'sd1 <<< (bits - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic signed [63:0] elem(input logic [N*N*W-1:0] v, input int i, input int j);
      logic signed [W-1:0] t;
      t = v[(i*N+j)*W +: W];
      return 64'(t);
   endfunction

   // C = A*B, C + A*B or A.*B with per-product, per-sum and final saturation.
   task automatic model(input int d, input int md);
      int     frac;
      longint t, c, acc, s, r;
      bit     ov;
      frac = (d == 1) ? 16 : 0;
      ov = 0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (md == 1) begin
               t = (ma[i][j] * mb[i][j]) >>> frac;
               acc = clampv(t, ACCW);
               if (acc != t) ov = 1;
            end else begin
               acc = (md == 2) ? prev[d][i][j] : 0;
               for (int k = 0; k < N; k++) begin
                  t = (ma[i][k] * mb[k][j]) >>> frac;
                  c = clampv(t, ACCW);
                  if (c != t) ov = 1;
                  s = acc + c;
                  acc = clampv(s, ACCW);
                  if (acc != s) ov = 1;
               end
            end
            r = clampv(acc, W);
            if (r != acc) ov = 1;
            expr[d][i][j] = r;
         end
      end
      eovf[d] = ov;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            prev[d][i][j] = expr[d][i][j];
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         eovf[d] = 0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               prev[d][i][j] = 0;
               expr[d][i][j] = 0;
            end
      end
   endtask

   task automatic check_result(input string tag);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            check($sformatf("%s_r0[%0d][%0d]", tag, i, j), elem(res0, i, j), expr[0][i][j]);
            check($sformatf("%s_r16[%0d][%0d]", tag, i, j), elem(res1, i, j), expr[1][i][j]);
         end
      check({tag, "_ovf0"}, 64'(ovf0), 64'(eovf[0]));
      check({tag, "_ovf16"}, 64'(ovf1), 64'(eovf[1]));
   endtask

   task automatic start_op(input string tag, input int md);
      model(0, md);
      model(1, md);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            dataa[(i*N+j)*W +: W] = ma[i][j][W-1:0];
            datab[(i*N+j)*W +: W] = mb[i][j][W-1:0];
         end
      mode  = 2'(md);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_e0"}, 64'(busy0), 64'd1);
   endtask

   task automatic wait_done(input string tag, input int lat);
      int cyc;
      bit seen;
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done0) seen = 1;
         else if (cyc < lat) check({tag, "_busy_mid"}, 64'(busy0), 64'd1);
      end
      check({tag, "_latency"}, 64'(cyc), 64'(lat));
      check({tag, "_done16"}, 64'(done1), 64'd1);
      check({tag, "_busy_done"}, 64'(busy0), 64'd0);
      check_result(tag);
   endtask

   task automatic check_single_done(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_done_once"}, 64'(done0), 64'd0);
   endtask

   function automatic longint rnd_val();
      logic [W-1:0] r;
      if ($urandom_range(0, 3) == 0) begin
         r = W'($urandom);
         return longint'($signed(r));
      end
      return longint'($urandom_range(0, 200)) - 100;
   endfunction

   task automatic fill(input longint av, input longint bv, input bit a_ident, input bit b_seq);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = a_ident ? ((i == j) ? av : 0) : av;
            mb[i][j] = b_seq ? longint'(i*N + j + 1) : ((i == j || bv != 64'sh10000 || !a_ident) ? bv : 0);
         end
   endtask

   initial begin
      clear_model();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_done", 64'(done0), 64'd0);
      check("rst_busy16", 64'(busy1), 64'd0);
      check_result("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      fill(1, 0, 1, 1);
      start_op("ident", 0);
      wait_done("ident", N + 1);
      check_single_done("ident");

      fill(2, 0, 0, 1);
      start_op("elem", 1);
      wait_done("elem", 2);
      check_single_done("elem");

      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_model();
      fill(1, 1, 0, 0);
      start_op("mac1", 2);
      wait_done("mac1", N + 1);
      start_op("mac2", 2);
      wait_done("mac2", N + 1);
      check_single_done("mac2");

      fill(64'sh10000, 64'sh10000, 1, 0);
      start_op("qident", 0);
      wait_done("qident", N + 1);

      fill(64'sh3FFFFFF, 64'sh10000, 0, 0);
      start_op("qsat", 0);
      wait_done("qsat", N + 1);
      check("qsat_ovf_set", 64'(ovf1), 64'd1);

      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = rnd_val();
            mb[i][j] = rnd_val();
         end
      start_op("ign", 0);
      dataa = {N*N{W'($urandom)}};
      datab = {N*N{W'($urandom)}};
      mode  = 2'b01;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ign", N);
      mode  = 2'b11;
      start = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("ill_busy", 64'(busy0), 64'd0);
         check("ill_done", 64'(done0), 64'd0);
      end
      start = 1'b0;
      check_result("ill");

      fill(3, 5, 0, 0);
      start_op("abort", 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_model();
      check("abort_busy", 64'(busy0), 64'd0);
      check_result("abort");
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         check("abort_nodone", 64'(done0), 64'd0);
      end
      fill(1, 0, 1, 1);
      start_op("post", 0);
      wait_done("post", N + 1);

      for (int it = 0; it < 20; it++) begin
         int md;
         md = $urandom_range(0, 2);
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ma[i][j] = rnd_val();
               mb[i][j] = rnd_val();
            end
         start_op($sformatf("rnd%0d", it), md);
         wait_done($sformatf("rnd%0d", it), (md == 1) ? 2 : N + 1);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
